// File: rtl/i2c_slave_rx.sv
// I2C target-side write receiver: oversampled SCL/SDA, START/STOP detection,
// 7-bit address match with ACK, and a byte stream out to the fabric.
module i2c_slave_rx #(
  parameter logic [6:0] SLAVE_ADDR  = 7'h50,
  parameter int         SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       scl_in,
  input  logic       sda_in,
  output logic       sda_oe,
  input  logic       rx_ready,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       busy,
  output logic       start_det,
  output logic       stop_det
);

  typedef enum logic [2:0] {
    IDLE, ADDR, ADDR_ACK, DATA, DATA_ACK, IGNORE
  } state_t;

  logic [SYNC_STAGES-1:0] scl_sync_q, scl_sync_d;
  logic [SYNC_STAGES-1:0] sda_sync_q, sda_sync_d;
  logic                   scl_hist_q, sda_hist_q;
  logic                   scl_s, sda_s;
  logic                   scl_rise, scl_fall, start_cond, stop_cond;
  logic                   bit_rx, byte_done;

  state_t     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [7:0] shift_q, shift_d;
  logic [7:0] rx_data_q, rx_data_d;
  logic       sda_oe_q, sda_oe_d;
  logic       rx_valid_q, rx_valid_d;
  logic       busy_q, busy_d;
  logic       start_det_q, start_det_d;
  logic       stop_det_q, stop_det_d;

  // Bit 0 is the newest sample; the top stage feeds edge detection.
  always_comb begin
    scl_sync_d = {scl_sync_q[SYNC_STAGES-2:0], scl_in};
    sda_sync_d = {sda_sync_q[SYNC_STAGES-2:0], sda_in};
  end

  assign scl_s      = scl_sync_q[SYNC_STAGES-1];
  assign sda_s      = sda_sync_q[SYNC_STAGES-1];
  assign scl_rise   = scl_s & ~scl_hist_q;
  assign scl_fall   = ~scl_s & scl_hist_q;
  assign start_cond = scl_s & sda_hist_q & ~sda_s;
  assign stop_cond  = scl_s & ~sda_hist_q & sda_s;
  assign bit_rx     = scl_rise & ((state_q == ADDR) | (state_q == DATA)) & (cnt_q < 4'd8);
  assign byte_done  = scl_fall & (cnt_q == 4'd8);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    shift_d     = shift_q;
    rx_data_d   = rx_data_q;
    sda_oe_d    = sda_oe_q;
    rx_valid_d  = 1'b0;
    busy_d      = busy_q;
    start_det_d = 1'b0;
    stop_det_d  = 1'b0;

    if (start_cond) begin
      start_det_d = 1'b1;
      sda_oe_d    = 1'b0;
      busy_d      = 1'b0;
      cnt_d       = 4'd0;
      state_d     = ADDR;
    end else if (stop_cond) begin
      stop_det_d = 1'b1;
      sda_oe_d   = 1'b0;
      busy_d     = 1'b0;
      state_d    = IDLE;
    end else begin
      if (bit_rx) begin
        shift_d = {shift_q[6:0], sda_s};
        cnt_d   = cnt_q + 4'd1;
      end
      case (state_q)
        ADDR: if (byte_done) begin
          if (shift_q[7:1] == SLAVE_ADDR && !shift_q[0]) begin
            sda_oe_d = 1'b1;
            busy_d   = 1'b1;
            state_d  = ADDR_ACK;
          end else begin
            sda_oe_d = 1'b0;
            state_d  = IGNORE;
          end
        end
        ADDR_ACK, DATA_ACK: if (scl_fall) begin
          sda_oe_d = 1'b0;
          cnt_d    = 4'd0;
          state_d  = DATA;
        end
        DATA: if (byte_done) begin
          // A byte the fabric cannot take is NACKed and the rest of the write dropped.
          if (rx_ready) begin
            rx_data_d  = shift_q;
            rx_valid_d = 1'b1;
            sda_oe_d   = 1'b1;
            state_d    = DATA_ACK;
          end else begin
            sda_oe_d = 1'b0;
            busy_d   = 1'b0;
            state_d  = IGNORE;
          end
        end
        IGNORE:  sda_oe_d = 1'b0;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scl_sync_q  <= '1;
      sda_sync_q  <= '1;
      scl_hist_q  <= 1'b1;
      sda_hist_q  <= 1'b1;
      state_q     <= IDLE;
      cnt_q       <= 4'd0;
      shift_q     <= 8'h00;
      rx_data_q   <= 8'h00;
      sda_oe_q    <= 1'b0;
      rx_valid_q  <= 1'b0;
      busy_q      <= 1'b0;
      start_det_q <= 1'b0;
      stop_det_q  <= 1'b0;
    end else begin
      scl_sync_q  <= scl_sync_d;
      sda_sync_q  <= sda_sync_d;
      scl_hist_q  <= scl_s;
      sda_hist_q  <= sda_s;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      shift_q     <= shift_d;
      rx_data_q   <= rx_data_d;
      sda_oe_q    <= sda_oe_d;
      rx_valid_q  <= rx_valid_d;
      busy_q      <= busy_d;
      start_det_q <= start_det_d;
      stop_det_q  <= stop_det_d;
    end
  end

  assign sda_oe    = sda_oe_q;
  assign rx_data   = rx_data_q;
  assign rx_valid  = rx_valid_q;
  assign busy      = busy_q;
  assign start_det = start_det_q;
  assign stop_det  = stop_det_q;

endmodule

// File: tb/tb_i2c_slave_rx.sv
// Bench for i2c_slave_rx: a timed I2C master on the pins, a vector table of
// write transactions, and a scoreboard of bytes the fabric should receive.
module tb_i2c_slave_rx;
  localparam int H = 200;

  logic clk = 1'b0, rst = 1'b1, scl = 1'b1, sda_m = 1'b1, rx_ready = 1'b0;
  logic sda_bus, sda_oe, rx_valid, busy, start_det, stop_det;
  logic [7:0] rx_data;

  assign sda_bus = sda_m & ~sda_oe;

  i2c_slave_rx #(.SLAVE_ADDR(7'h50), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst(rst), .scl_in(scl), .sda_in(sda_bus), .sda_oe(sda_oe),
    .rx_ready(rx_ready), .rx_data(rx_data), .rx_valid(rx_valid), .busy(busy),
    .start_det(start_det), .stop_det(stop_det)
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0;
  int start_cnt = 0, stop_cnt = 0, rxv_cnt = 0;
  logic [7:0] exp_q[$];
  logic [7:0] mon_e;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h", name, act, exp);
    end
  endtask

  // Scoreboard side: every rx_valid must match the oldest expected byte.
  always @(negedge clk) begin
    if (!rst) begin
      if (start_det) start_cnt++;
      if (stop_det)  stop_cnt++;
      if (rx_valid) begin
        rxv_cnt++;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL rx_unexpected act=%0h exp=none", rx_data);
        end else begin
          mon_e = exp_q.pop_front();
          chk("rx_data_sb", {24'd0, rx_data}, {24'd0, mon_e});
        end
      end
    end
  end

  task automatic i2c_start();
    #(H/2) sda_m = 1'b0;
    #(H/2) scl = 1'b0;
  endtask

  task automatic rep_start();
    #(H/2) sda_m = 1'b1;
    #(H/2) scl = 1'b1;
    #(H/2) sda_m = 1'b0;
    #(H/2) scl = 1'b0;
  endtask

  task automatic i2c_stop();
    #(H/2) sda_m = 1'b0;
    #(H/2) scl = 1'b1;
    #(H/2) sda_m = 1'b1;
    #(H/2);
  endtask

  task automatic send_bit(input logic b, output logic s);
    #(H/2) sda_m = b;
    #(H/2) scl = 1'b1;
    #(H/2) s = sda_bus;
    #(H/2) scl = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, output logic ack);
    logic s;
    for (int i = 7; i >= 0; i--) send_bit(b[i], s);
    send_bit(1'b1, s);
    ack = ~s;
  endtask

  typedef struct {
    logic [7:0] addr, d0, d1;
    int         n;
    logic       rdy0, rdy1, ack_a, ack0, ack1;
    logic [7:0] rx_end;
  } vec_t;

  vec_t tbl[5];

  initial begin
    vec_t v;
    logic a, rdy, ak;
    logic [7:0] d, ab;
    int s0, p0, r0, nexp;

    tbl[0] = '{8'hA0, 8'h3C, 8'h00, 1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 8'h3C};
    tbl[1] = '{8'hA2, 8'h55, 8'h00, 1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h3C};
    tbl[2] = '{8'hA1, 8'h00, 8'h00, 0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h3C};
    tbl[3] = '{8'hA0, 8'h11, 8'h22, 2, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 8'h11};
    tbl[4] = '{8'hA0, 8'hAB, 8'hCD, 2, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 8'hCD};

    #40;
    chk("rst_sda_oe", sda_oe, 0);
    chk("rst_rx_data", rx_data, 0);
    chk("rst_rx_valid", rx_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_start_det", start_det, 0);
    chk("rst_stop_det", stop_det, 0);
    rst = 1'b0;
    #H;

    for (int i = 0; i < 5; i++) begin
      v = tbl[i];
      s0 = start_cnt; p0 = stop_cnt; r0 = rxv_cnt; nexp = 0;
      i2c_start();
      send_byte(v.addr, a);
      chk("addr_ack", a, v.ack_a);
      chk("busy_addr", busy, v.ack_a);
      for (int j = 0; j < v.n; j++) begin
        d   = (j == 0) ? v.d0 : v.d1;
        rdy = (j == 0) ? v.rdy0 : v.rdy1;
        ak  = (j == 0) ? v.ack0 : v.ack1;
        rx_ready = rdy;
        if (ak) begin
          exp_q.push_back(d);
          nexp++;
        end
        send_byte(d, a);
        chk("data_ack", a, ak);
        chk("busy_data", busy, ak);
      end
      i2c_stop();
      #H;
      chk("busy_end", busy, 0);
      chk("rx_data_end", rx_data, v.rx_end);
      chk("start_pulses", start_cnt - s0, 1);
      chk("stop_pulses", stop_cnt - p0, 1);
      chk("rx_valid_pulses", rxv_cnt - r0, nexp);
      chk("sb_empty", exp_q.size(), 0);
    end

    // Repeated START in the middle of a data byte.
    rx_ready = 1'b1;
    s0 = start_cnt; r0 = rxv_cnt;
    i2c_start();
    send_byte(8'hA0, a);
    chk("rs_addr_ack", a, 1);
    for (int k = 0; k < 4; k++) send_bit(1'b1, a);
    rep_start();
    send_byte(8'hA0, a);
    chk("rs_addr2_ack", a, 1);
    exp_q.push_back(8'h7E);
    send_byte(8'h7E, a);
    chk("rs_data_ack", a, 1);
    i2c_stop();
    #H;
    chk("rs_start_pulses", start_cnt - s0, 2);
    chk("rs_rx_pulses", rxv_cnt - r0, 1);
    chk("rs_rx_data", rx_data, 8'h7E);
    chk("rs_busy", busy, 0);

    // Reset asserted while the slave is driving the address ACK.
    ab = 8'hA0;
    i2c_start();
    for (int k = 7; k >= 0; k--) send_bit(ab[k], a);
    #(H/2) sda_m = 1'b1;
    #(H/2) scl = 1'b1;
    #60;
    chk("ra_oe_before", sda_oe, 1);
    rst = 1'b1;
    #1;
    chk("ra_sda_oe", sda_oe, 0);
    chk("ra_rx_data", rx_data, 0);
    chk("ra_rx_valid", rx_valid, 0);
    chk("ra_busy", busy, 0);
    chk("ra_start_det", start_det, 0);
    chk("ra_stop_det", stop_det, 0);
    #9 rst = 1'b0;
    #30 scl = 1'b0;
    r0 = rxv_cnt;
    send_byte(8'h99, a);
    chk("ra_ignore_ack", a, 0);
    chk("ra_ignore_busy", busy, 0);
    i2c_stop();
    i2c_start();
    send_byte(8'hA0, a);
    chk("ra_addr_ack", a, 1);
    exp_q.push_back(8'h42);
    send_byte(8'h42, a);
    chk("ra_data_ack", a, 1);
    i2c_stop();
    #H;
    chk("ra_rx_pulses", rxv_cnt - r0, 1);
    chk("ra_rx_data_end", rx_data, 8'h42);
    chk("ra_sb_empty", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog");
  end
endmodule
